// File: rtl/conv_core_writeback.sv
// Write-back engine: stores result lines to memory over Avalon-MM, with optional
// locked read-modify-write accumulation (wrapping or saturating per signed lane).
module conv_core_writeback #(
  parameter int unsigned        DATA_W      = 512,
  parameter int unsigned        LANE_W      = 32,
  parameter int unsigned        ADDR_W      = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int unsigned        LINE_STRIDE = 64,
  parameter int unsigned        MAX_LINES   = 512,
  localparam int unsigned       CNT_W       = $clog2(MAX_LINES + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  Start_i,
  input  logic [CNT_W-1:0]      Lines_i,
  input  logic                  AccuEn_i,
  input  logic                  SatEn_i,
  input  logic [DATA_W-1:0]     WrData_i,
  input  logic                  WrReq_i,
  output logic                  WrAck_o,
  input  logic                  First_i,
  input  logic                  Last_i,
  output logic                  Halt_o,
  output logic [ADDR_W-1:0]     AvalonAddr_o,
  output logic                  AvalonRead_o,
  output logic                  AvalonWrite_o,
  output logic [DATA_W/8-1:0]   AvalonByteEnable_o,
  output logic [DATA_W-1:0]     AvalonWriteData_o,
  input  logic [DATA_W-1:0]     AvalonReadData_i,
  input  logic                  AvalonReadDataValid_i,
  output logic                  AvalonLock_o,
  input  logic                  AvalonWaitReq_i,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic                  Err_o
);

  localparam int unsigned N_LANES = DATA_W / LANE_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_lines;
  logic                r_accu;
  logic                r_sat;
  logic                r_last;
  logic                r_err;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   w_sum;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_is_final;

  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_is_final = (w_cnt_inc == r_lines);

  // Per-lane signed add; one extra bit exposes overflow as a sign-bit disagreement
  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] w_a;
      logic [LANE_W-1:0] w_b;
      logic [LANE_W:0]   w_ext;
      logic              w_ovf;
      assign w_a   = r_hold[gi*LANE_W +: LANE_W];
      assign w_b   = AvalonReadData_i[gi*LANE_W +: LANE_W];
      assign w_ext = {w_a[LANE_W-1], w_a} + {w_b[LANE_W-1], w_b};
      assign w_ovf = w_ext[LANE_W] ^ w_ext[LANE_W-1];
      assign w_sum[gi*LANE_W +: LANE_W] =
        (r_sat && w_ovf) ? (w_ext[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                          : {1'b0, {(LANE_W-1){1'b1}}})
                         : w_ext[LANE_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (Start_i) w_state_next = (Lines_i == '0) ? S_DONE : S_WAIT_DATA;
      S_WAIT_DATA: if (WrReq_i) w_state_next = r_accu ? S_RD_REQ : S_WR_REQ;
      S_RD_REQ:    if (!AvalonWaitReq_i) w_state_next = S_RD_WAIT;
      S_RD_WAIT:   if (AvalonReadDataValid_i) w_state_next = S_WR_REQ;
      S_WR_REQ:    if (!AvalonWaitReq_i) w_state_next = (w_is_final || r_last) ? S_DONE : S_WAIT_DATA;
      S_DONE:      w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_lines <= '0;
      r_accu  <= 1'b0;
      r_sat   <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start_i) begin
            r_lines <= Lines_i;
            r_accu  <= AccuEn_i;
            r_sat   <= SatEn_i;
            r_addr  <= BASE_ADDR;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        S_WAIT_DATA: begin
          if (WrReq_i) begin
            r_hold <= WrData_i;
            r_last <= Last_i;
            // Last must coincide exactly with the final line; First only on line 0
            if ((First_i && (r_cnt != '0)) || (Last_i != w_is_final))
              r_err <= 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (AvalonReadDataValid_i) r_hold <= w_sum;
        end
        S_WR_REQ: begin
          if (!AvalonWaitReq_i) begin
            r_addr <= r_addr + ADDR_W'(LINE_STRIDE);
            r_cnt  <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign WrAck_o            = (r_state == S_WAIT_DATA);
  assign Halt_o             = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) || (r_state == S_WR_REQ);
  assign AvalonRead_o       = (r_state == S_RD_REQ);
  assign AvalonWrite_o      = (r_state == S_WR_REQ);
  assign AvalonByteEnable_o = (AvalonRead_o || AvalonWrite_o) ? {(DATA_W/8){1'b1}} : '0;
  assign AvalonAddr_o       = r_addr;
  assign AvalonWriteData_o  = r_hold;
  assign AvalonLock_o       = r_accu && Halt_o;
  assign Busy_o             = (r_state != S_IDLE);
  assign Done_o             = (r_state == S_DONE);
  assign Err_o              = r_err;

endmodule

// File: tb/tb_conv_core_writeback.sv
// Directed bench for conv_core_writeback: stimulus pushes expected writes, a negedge
// monitor pops and compares them as the bus accepts writes; a small memory answers reads.
module tb_conv_core_writeback;
  localparam int DW = 64;
  localparam int LW = 32;
  localparam int AW = 32;
  localparam int ML = 8;
  localparam int CW = $clog2(ML + 1);
  localparam logic [AW-1:0] BASE = 32'h0000_1000;

  logic           clk, rstn;
  logic           Start_i, AccuEn_i, SatEn_i, WrReq_i, First_i, Last_i;
  logic [CW-1:0]  Lines_i;
  logic [DW-1:0]  WrData_i;
  logic           WrAck_o, Halt_o, AvalonRead_o, AvalonWrite_o, AvalonLock_o;
  logic [AW-1:0]  AvalonAddr_o;
  logic [DW/8-1:0] AvalonByteEnable_o;
  logic [DW-1:0]  AvalonWriteData_o, AvalonReadData_i;
  logic           AvalonReadDataValid_i, AvalonWaitReq_i;
  logic           Busy_o, Done_o, Err_o;

  conv_core_writeback #(
    .DATA_W(DW), .LANE_W(LW), .ADDR_W(AW), .BASE_ADDR(BASE),
    .LINE_STRIDE(64), .MAX_LINES(ML)
  ) dut (
    .clk(clk), .rstn(rstn), .Start_i(Start_i), .Lines_i(Lines_i),
    .AccuEn_i(AccuEn_i), .SatEn_i(SatEn_i), .WrData_i(WrData_i), .WrReq_i(WrReq_i),
    .WrAck_o(WrAck_o), .First_i(First_i), .Last_i(Last_i), .Halt_o(Halt_o),
    .AvalonAddr_o(AvalonAddr_o), .AvalonRead_o(AvalonRead_o), .AvalonWrite_o(AvalonWrite_o),
    .AvalonByteEnable_o(AvalonByteEnable_o), .AvalonWriteData_o(AvalonWriteData_o),
    .AvalonReadData_i(AvalonReadData_i), .AvalonReadDataValid_i(AvalonReadDataValid_i),
    .AvalonLock_o(AvalonLock_o), .AvalonWaitReq_i(AvalonWaitReq_i),
    .Busy_o(Busy_o), .Done_o(Done_o), .Err_o(Err_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          lock;
  } wr_t;

  wr_t            exp_q[$];
  wr_t            mon_e;
  logic [DW-1:0]  mem [logic [AW-1:0]];
  int             n_checks = 0;
  int             n_errs = 0;
  int             cyc = 0;
  int             n_wr = 0;
  int             n_rd = 0;
  int             last_wr_cyc = 0;
  logic           rd_acc = 1'b0;
  logic [AW-1:0]  rd_acc_addr = '0;
  logic           hold_rvalid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every accepted write is popped against the scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (AvalonRead_o || AvalonWrite_o)
        chk("rd_wr_exclusive", AvalonRead_o & AvalonWrite_o, 0);
      if (AvalonRead_o && !AvalonWaitReq_i) begin
        n_rd++;
        rd_acc      = 1'b1;
        rd_acc_addr = AvalonAddr_o;
      end
      if (AvalonWrite_o && !AvalonWaitReq_i) begin
        n_wr++;
        last_wr_cyc = cyc;
        mem[AvalonAddr_o] = AvalonWriteData_o;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_write: got write at %h, required none", AvalonAddr_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", AvalonAddr_o, mon_e.addr);
          chk("wr_data", AvalonWriteData_o, mon_e.data);
          chk("wr_lock", AvalonLock_o, mon_e.lock);
          chk("wr_be", AvalonByteEnable_o, 8'hFF);
        end
      end
    end
  end

  // Memory responder: read data valid the cycle after the read is accepted
  always @(posedge clk) begin
    #1;
    if (rd_acc && !hold_rvalid) begin
      AvalonReadDataValid_i = 1'b1;
      AvalonReadData_i      = mem.exists(rd_acc_addr) ? mem[rd_acc_addr] : '0;
      rd_acc                = 1'b0;
    end else begin
      AvalonReadDataValid_i = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int lines, input logic accu, input logic sat);
    Lines_i  = CW'(lines);
    AccuEn_i = accu;
    SatEn_i  = sat;
    Start_i  = 1'b1;
    tick();
    Start_i  = 1'b0;
  endtask

  task automatic send_line(input logic [DW-1:0] d, input logic f, input logic l);
    bit got = 0;
    WrData_i = d; First_i = f; Last_i = l; WrReq_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (WrAck_o) begin got = 1; break; end
    end
    if (!got) begin
      n_checks++; n_errs++;
      $display("FAIL line_accept_timeout: got no WrAck_o, required acceptance");
    end
    tick();
    WrReq_i = 1'b0; First_i = 1'b0; Last_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    bit got = 0;
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (Done_o) begin got = 1; dcyc = cyc; break; end
    end
    if (!got) begin
      n_checks++; n_errs++;
      $display("FAIL done_timeout: got no Done_o in %0d cycles, required pulse", budget);
    end else begin
      chk("lock_in_done", AvalonLock_o, 0);
      @(negedge clk);
      chk("done_one_cycle", Done_o, 0);
      chk("idle_not_busy", Busy_o, 0);
    end
    tick();
  endtask

  task automatic accu_case(input logic [DW-1:0] mv, input logic [DW-1:0] iv,
                           input logic sat, input logic [DW-1:0] ev);
    int  dc;
    bit  got = 0;
    logic prev_rv = 1'b0;
    mem[BASE] = mv;
    start_job(1, 1'b1, sat);
    exp_q.push_back('{BASE, ev, 1'b1});
    send_line(iv, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("lock_held", AvalonLock_o, 1);
      chk("halt_held", Halt_o, 1);
      if (AvalonWrite_o && !AvalonWaitReq_i) begin
        got = 1;
        chk("accu_wr_after_rvalid", prev_rv, 1);
        break;
      end
      prev_rv = AvalonReadDataValid_i;
    end
    if (!got) begin
      n_checks++; n_errs++;
      $display("FAIL accu_write_timeout: got no write, required one");
    end
    wait_done(5, dc);
    chk("accu_err", Err_o, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, Busy_o, 0);
    chk({tag, "_done"}, Done_o, 0);
    chk({tag, "_err"}, Err_o, 0);
    chk({tag, "_wrack"}, WrAck_o, 0);
    chk({tag, "_halt"}, Halt_o, 0);
    chk({tag, "_read"}, AvalonRead_o, 0);
    chk({tag, "_write"}, AvalonWrite_o, 0);
    chk({tag, "_lock"}, AvalonLock_o, 0);
    chk({tag, "_addr"}, AvalonAddr_o, 0);
    chk({tag, "_be"}, AvalonByteEnable_o, 0);
    chk({tag, "_wdata"}, AvalonWriteData_o, 0);
  endtask

  initial begin
    int dc, b_wr, b_rd;
    rstn = 1'b0; Start_i = 0; AccuEn_i = 0; SatEn_i = 0; Lines_i = '0;
    WrData_i = '0; WrReq_i = 0; First_i = 0; Last_i = 0;
    AvalonWaitReq_i = 0; AvalonReadDataValid_i = 0; AvalonReadData_i = '0;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rstn = 1'b1;
    tick();

    // 1: three plain writes
    start_job(3, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_after_start", Busy_o, 1);
    tick();
    exp_q.push_back('{BASE,         64'h1111_0000_AAAA_0001, 1'b0});
    exp_q.push_back('{BASE + 32'h40, 64'h2222_0000_BBBB_0002, 1'b0});
    exp_q.push_back('{BASE + 32'h80, 64'h3333_0000_CCCC_0003, 1'b0});
    send_line(64'h1111_0000_AAAA_0001, 1'b1, 1'b0);
    @(negedge clk);
    chk("plain_wr_latency", AvalonWrite_o, 1);
    tick();
    send_line(64'h2222_0000_BBBB_0002, 1'b0, 1'b0);
    send_line(64'h3333_0000_CCCC_0003, 1'b0, 1'b1);
    wait_done(20, dc);
    chk("done_after_last_wr", dc - last_wr_cyc, 1);
    chk("t1_err", Err_o, 0);

    // 2: waitrequest held for 5 cycles during a write
    start_job(1, 1'b0, 1'b0);
    exp_q.push_back('{BASE, 64'hDEAD_BEEF_0BAD_F00D, 1'b0});
    AvalonWaitReq_i = 1'b1;
    send_line(64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_write", AvalonWrite_o, 1);
      chk("stall_addr", AvalonAddr_o, BASE);
      chk("stall_data", AvalonWriteData_o, 64'hDEAD_BEEF_0BAD_F00D);
      chk("stall_halt", Halt_o, 1);
      chk("stall_wrack", WrAck_o, 0);
    end
    tick();
    AvalonWaitReq_i = 1'b0;
    wait_done(10, dc);
    chk("t2_err", Err_o, 0);

    // 3: accumulate, wrapping and saturating (lane 0 = low 32 bits)
    accu_case({32'h0000_0005, 32'h7FFF_FFFF}, {32'h0000_0003, 32'h0000_0001}, 1'b0,
              {32'h0000_0008, 32'h8000_0000});
    accu_case({32'hFFFF_FFFE, 32'h7FFF_FFFF}, {32'h0000_0001, 32'h0000_0001}, 1'b1,
              {32'hFFFF_FFFF, 32'h7FFF_FFFF});
    accu_case({32'h8000_0000, 32'h8000_0000}, {32'h8000_0000, 32'hFFFF_FFFF}, 1'b1,
              {32'h8000_0000, 32'h8000_0000});
    accu_case({32'h8000_0000, 32'h8000_0000}, {32'h8000_0000, 32'hFFFF_FFFF}, 1'b0,
              {32'h0000_0000, 32'h7FFF_FFFF});
    accu_case({32'h0000_0010, 32'hFFFF_FFF0}, {32'hFFFF_FFF0, 32'h0000_0020}, 1'b1,
              {32'h0000_0000, 32'h0000_0010});

    // 4: early Last, then empty job, then misplaced First, then missing Last
    b_wr = n_wr;
    start_job(4, 1'b0, 1'b0);
    exp_q.push_back('{BASE,          64'h0000_0000_0000_00A0, 1'b0});
    exp_q.push_back('{BASE + 32'h40, 64'h0000_0000_0000_00A1, 1'b0});
    send_line(64'h0000_0000_0000_00A0, 1'b1, 1'b0);
    send_line(64'h0000_0000_0000_00A1, 1'b0, 1'b1);
    wait_done(20, dc);
    chk("early_last_done_after_wr", dc - last_wr_cyc, 1);
    chk("early_last_writes", n_wr - b_wr, 2);
    chk("early_last_err", Err_o, 1);

    b_wr = n_wr; b_rd = n_rd;
    start_job(0, 1'b0, 1'b0);
    wait_done(2, dc);
    chk("zero_lines_err_cleared", Err_o, 0);
    chk("zero_lines_no_writes", n_wr - b_wr, 0);
    chk("zero_lines_no_reads", n_rd - b_rd, 0);

    start_job(2, 1'b0, 1'b0);
    exp_q.push_back('{BASE,          64'h0000_0000_0000_00B0, 1'b0});
    exp_q.push_back('{BASE + 32'h40, 64'h0000_0000_0000_00B1, 1'b0});
    send_line(64'h0000_0000_0000_00B0, 1'b1, 1'b0);
    send_line(64'h0000_0000_0000_00B1, 1'b1, 1'b1);
    wait_done(20, dc);
    chk("late_first_err", Err_o, 1);

    start_job(1, 1'b0, 1'b0);
    exp_q.push_back('{BASE, 64'h0000_0000_0000_00C0, 1'b0});
    send_line(64'h0000_0000_0000_00C0, 1'b1, 1'b0);
    wait_done(20, dc);
    chk("missing_last_err", Err_o, 1);

    // 5: reset while waiting for read data
    mem[BASE] = 64'h0000_0001_0000_0001;
    start_job(1, 1'b1, 1'b0);
    hold_rvalid = 1'b1;
    send_line(64'h5555_5555_5555_5555, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (AvalonRead_o && !AvalonWaitReq_i) break;
    end
    @(negedge clk);
    chk("rdwait_lock", AvalonLock_o, 1);
    chk("rdwait_read_low", AvalonRead_o, 0);
    rstn = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    rstn = 1'b1;
    rd_acc = 1'b0;
    hold_rvalid = 1'b0;
    tick();
    start_job(2, 1'b0, 1'b0);
    exp_q.push_back('{BASE,          64'h0000_0000_0000_00D0, 1'b0});
    exp_q.push_back('{BASE + 32'h40, 64'h0000_0000_0000_00D1, 1'b0});
    send_line(64'h0000_0000_0000_00D0, 1'b1, 1'b0);
    send_line(64'h0000_0000_0000_00D1, 1'b0, 1'b1);
    wait_done(20, dc);
    chk("post_reset_err", Err_o, 0);

    // 6: Start while busy is ignored
    b_rd = n_rd;
    start_job(2, 1'b0, 1'b0);
    exp_q.push_back('{BASE,          64'h0000_0000_0000_00E0, 1'b0});
    exp_q.push_back('{BASE + 32'h40, 64'h0000_0000_0000_00E1, 1'b0});
    AvalonWaitReq_i = 1'b1;
    send_line(64'h0000_0000_0000_00E0, 1'b1, 1'b0);
    start_job(1, 1'b1, 1'b1);
    @(negedge clk);
    chk("busy_start_busy", Busy_o, 1);
    chk("busy_start_addr", AvalonAddr_o, BASE);
    chk("busy_start_write", AvalonWrite_o, 1);
    tick();
    AvalonWaitReq_i = 1'b0;
    tick();
    send_line(64'h0000_0000_0000_00E1, 1'b0, 1'b1);
    wait_done(20, dc);
    chk("busy_start_err", Err_o, 0);
    chk("busy_start_no_reads", n_rd - b_rd, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
